// File: rtl/reduction_dim_transposer_if.sv
// reduction_dim_transposer_if: input/output handshake bus of the slice transposer
interface reduction_dim_transposer_if #(
  parameter int DATA_W = 32,
  parameter int DIM2 = 3
);
  logic valid_in, in_ready, valid_out, out_ready, last_out;
  logic [DATA_W-1:0] input_data, output_data;
  logic [$clog2(DIM2)-1:0] col_idx;
  modport master(output valid_in, input_data, out_ready, input in_ready, valid_out, output_data, last_out, col_idx);
  modport slave(input valid_in, input_data, out_ready, output in_ready, valid_out, output_data, last_out, col_idx);
endinterface

// File: rtl/reduction_dim_transposer.sv
// reduction_dim_transposer: ping-pong buffered row-major to column-major slice transposer
module reduction_dim_transposer #(
  parameter int DATA_W = 32,
  parameter int DIM1 = 4,
  parameter int DIM2 = 3
) (
  input logic clk,
  input logic rst_n,
  reduction_dim_transposer_if.slave bus
);
  localparam int N = DIM1 * DIM2;
  localparam int AW = $clog2(N);
  localparam int W1 = $clog2(DIM1);
  localparam int W2 = $clog2(DIM2);
  logic [DATA_W-1:0] mem_q [2][N];
  logic [1:0] full_q, full_d;
  logic wsel_q, wsel_d, rsel_q, rsel_d;
  logic [AW-1:0] wcnt_q, wcnt_d, raddr;
  logic [W1-1:0] r1_q, r1_d;
  logic [W2-1:0] r2_q, r2_d, col_q, col_d;
  logic valid_q, valid_d, last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic wr, wdone, ld, r1_end, r2_end, rdone;
  always_comb begin
    wr = bus.valid_in & ~full_q[wsel_q];
    wdone = wr & (wcnt_q == AW'(N - 1));
    ld = full_q[rsel_q] & (~valid_q | bus.out_ready);
    r1_end = r1_q == W1'(DIM1 - 1);
    r2_end = r2_q == W2'(DIM2 - 1);
    rdone = ld & r1_end & r2_end;
    raddr = AW'(r1_q) * AW'(DIM2) + AW'(r2_q);
    full_d[0] = (full_q[0] | (wdone & ~wsel_q)) & ~(rdone & ~rsel_q);
    full_d[1] = (full_q[1] | (wdone & wsel_q)) & ~(rdone & rsel_q);
    wcnt_d = wr ? (wdone ? '0 : wcnt_q + AW'(1)) : wcnt_q;
    wsel_d = wsel_q ^ wdone;
    r1_d = ld ? (r1_end ? '0 : r1_q + W1'(1)) : r1_q;
    r2_d = (ld & r1_end) ? (r2_end ? '0 : r2_q + W2'(1)) : r2_q;
    rsel_d = rsel_q ^ rdone;
    valid_d = ld | (valid_q & ~bus.out_ready);
    data_d = ld ? mem_q[rsel_q][raddr] : data_q;
    last_d = ld ? r1_end : last_q;
    col_d = ld ? r2_q : col_q;
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wsel_q][wcnt_q] <= bus.input_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      wcnt_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      col_q <= '0;
    end else begin
      full_q <= full_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      wcnt_q <= wcnt_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      valid_q <= valid_d;
      last_q <= last_d;
      data_q <= data_d;
      col_q <= col_d;
    end
  end
  assign bus.in_ready = ~full_q[wsel_q];
  assign bus.valid_out = valid_q;
  assign bus.output_data = data_q;
  assign bus.last_out = last_q;
  assign bus.col_idx = col_q;
endmodule
